// File: rtl/truth_table_extractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cello_eval_pkg
// Description : Shared widths and sweep state encoding for the truth-table
//               extractor.
// Revision    : 1.0 - initial release
// ============================================================================
package cello_eval_pkg;

    localparam int ROW_W   = 3;
    localparam int TABLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_APPLY    = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_SAMPLE_A = 3'd3,
        ST_SAMPLE_B = 3'd4,
        ST_FINISH   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/truth_table_extractor_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_extractor_if
// Description : Control/result bundle between a host and the extractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_extractor_if;
    import cello_eval_pkg::*;

    logic               start;
    logic [TABLE_W-1:0] expected;
    logic               busy;
    logic               done;
    logic [TABLE_W-1:0] table_out;
    logic               match;
    logic               stable;

    modport master (
        output start, expected,
        input  busy, done, table_out, match, stable
    );

    modport slave (
        input  start, expected,
        output busy, done, table_out, match, stable
    );

endinterface
`default_nettype wire

// File: rtl/truth_table_extractor_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : settle_timer
// Description : Loadable down-counter; expire flags the last settle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_value,
    input  wire logic             count,
    output logic                  expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (count && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign expire = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/truth_table_extractor.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_extractor
// Description : Sweeps all 8 input rows of a 3-input circuit, samples each row
//               twice and reports the recovered Cello hex code.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_extractor
    import cello_eval_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    truth_table_extractor_if.slave  bus,
    output logic                    cut_in1,
    output logic                    cut_in2,
    output logic                    cut_in3,
    input  wire logic               cut_out
);

    localparam int                 c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_SETTLE   = c_CNT_W'(SETTLE_CYCLES);
    localparam logic [ROW_W-1:0]   c_LAST_ROW = ROW_W'(TABLE_W - 1);

    state_t             r_state;
    logic [ROW_W-1:0]   r_row;
    logic [TABLE_W-1:0] r_expected;
    logic [TABLE_W-1:0] r_acc;
    logic               r_stable_acc;
    logic               r_busy;
    logic               r_done;
    logic [TABLE_W-1:0] r_table;
    logic               r_match;
    logic               r_stable;

    logic               w_expire;
    logic [ROW_W-1:0]   w_bit_idx;
    logic               w_stable_next;

    // Row 0 lands in the code MSB.
    assign w_bit_idx     = c_LAST_ROW - r_row;
    assign w_stable_next = r_stable_acc & (cut_out == r_acc[w_bit_idx]);

    settle_timer #(
        .CNT_W      (c_CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (r_state == ST_APPLY),
        .load_value (c_SETTLE),
        .count      (r_state == ST_SETTLE),
        .expire     (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_expected   <= '0;
            r_acc        <= '0;
            r_stable_acc <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_table      <= '0;
            r_match      <= 1'b0;
            r_stable     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_expected   <= bus.expected;
                        r_acc        <= '0;
                        r_stable_acc <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_expire) begin
                        r_state <= ST_SAMPLE_A;
                    end
                end
                ST_SAMPLE_A: begin
                    r_acc[w_bit_idx] <= cut_out;
                    r_state          <= ST_SAMPLE_B;
                end
                ST_SAMPLE_B: begin
                    r_stable_acc <= w_stable_next;
                    r_row        <= r_row + ROW_W'(1);
                    // Results are registered on the way into FINISH so they
                    // are visible exactly while done is high.
                    if (r_row == c_LAST_ROW) begin
                        r_state  <= ST_FINISH;
                        r_done   <= 1'b1;
                        r_table  <= r_acc;
                        r_match  <= (r_acc == r_expected);
                        r_stable <= w_stable_next;
                    end else begin
                        r_state <= ST_APPLY;
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cut_in1       = r_row[2];
    assign cut_in2       = r_row[1];
    assign cut_in3       = r_row[0];

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.table_out = r_table;
    assign bus.match     = r_match;
    assign bus.stable    = r_stable;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_extractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_extractor
// Description : Scoreboard bench for two extractor instances (settle 2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_extractor;

    localparam int S0 = 2;
    localparam int S1 = 1;

    typedef struct {
        logic [7:0] tbl;
        logic       m;
        logic       st;
        int         se;
        int         lat;
    } exp_t;

    logic clk;
    logic rst;
    int   gcyc;
    int   n_cmp;
    int   n_fail;

    exp_t q0[$];
    exp_t q1[$];

    truth_table_extractor_if bus0();
    truth_table_extractor_if bus1();

    logic c0_in1, c0_in2, c0_in3, c0_out;
    logic c1_in1, c1_in2, c1_in3, c1_out;

    int         mode0, mode1;
    logic [7:0] code0, code1;
    logic       glitch0;
    int         cnt3;

    truth_table_extractor #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .cut_in1(c0_in1), .cut_in2(c0_in2), .cut_in3(c0_in3), .cut_out(c0_out)
    );

    truth_table_extractor #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .cut_in1(c1_in1), .cut_in2(c1_in2), .cut_in3(c1_in3), .cut_out(c1_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) gcyc <= gcyc + 1;

    // Circuit under test: mode 0 = gate-level 0xA6 circuit, 1 = tied high, 2 = arbitrary code.
    function automatic logic cut_fn(int mode, logic [7:0] code, logic [2:0] row);
        logic [7:0] c;
        c = code;
        case (mode)
            0:       return ~((row[2] & ~row[1]) ^ row[0]);
            1:       return 1'b1;
            default: return c[3'd7 - row];
        endcase
    endfunction

    function automatic logic [7:0] ref_table(int mode, logic [7:0] code);
        logic [7:0] t;
        t = '0;
        for (int r = 0; r < 8; r++) t[7-r] = cut_fn(mode, code, 3'(r));
        return t;
    endfunction

    // Cycles already spent on row 3; the SAMPLE_B cycle of that row sees S0+2.
    always @(posedge clk) begin
        if (rst) cnt3 <= 0;
        else if ({c0_in1, c0_in2, c0_in3} == 3'd3) cnt3 <= cnt3 + 1;
        else cnt3 <= 0;
    end

    assign c0_out = cut_fn(mode0, code0, {c0_in1, c0_in2, c0_in3}) ^
                    (glitch0 && ({c0_in1, c0_in2, c0_in3} == 3'd3) && (cnt3 == S0 + 2));
    assign c1_out = cut_fn(mode1, code1, {c1_in1, c1_in2, c1_in3});

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: done pulse with no sweep outstanding (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && bus0.done) begin
            if (q0.size() == 0) unexpected("done0");
            else begin
                exp_t e;
                e = q0.pop_front();
                check("table0",   bus0.table_out, e.tbl);
                check("match0",   bus0.match, e.m);
                check("stable0",  bus0.stable, e.st);
                check("latency0", gcyc - e.se + 1, e.lat);
                check("busy_at_done0", bus0.busy, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.done) begin
            if (q1.size() == 0) unexpected("done1");
            else begin
                exp_t e;
                e = q1.pop_front();
                check("table1",   bus1.table_out, e.tbl);
                check("match1",   bus1.match, e.m);
                check("stable1",  bus1.stable, e.st);
                check("latency1", gcyc - e.se + 1, e.lat);
            end
        end
    end

    task automatic check_reset0(string tag);
        check({tag, "_busy"},   bus0.busy, 0);
        check({tag, "_done"},   bus0.done, 0);
        check({tag, "_table"},  bus0.table_out, 8'h00);
        check({tag, "_match"},  bus0.match, 0);
        check({tag, "_stable"}, bus0.stable, 1);
        check({tag, "_cut_in"}, {c0_in1, c0_in2, c0_in3}, 3'd0);
    endtask

    task automatic run0(logic [7:0] ex, int mode, logic [7:0] code, logic glitch,
                        int restart_at, int rst_at);
        logic [7:0] t;
        int         se;
        t = ref_table(mode, code);
        mode0 = mode; code0 = code; glitch0 = glitch;
        @(negedge clk);
        bus0.start = 1'b1; bus0.expected = ex;
        @(posedge clk); #1;
        bus0.start = 1'b0; bus0.expected = 8'($urandom);
        se = gcyc;
        if (rst_at < 0) q0.push_back('{t, (t == ex), !glitch, se, 8*(S0+3)+1});
        check("busy_after_start0", bus0.busy, 1);
        if (restart_at > 0) begin
            repeat (restart_at) @(negedge clk);
            bus0.start = 1'b1; bus0.expected = ~ex;
            @(negedge clk);
            bus0.start = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at) @(negedge clk);
            rst = 1'b1;
            #1;
            check_reset0("abort");
            @(negedge clk);
            rst = 1'b0;
            repeat (50) @(negedge clk);
        end else begin
            for (int i = 0; i < 200 && q0.size() != 0; i++) @(negedge clk);
            if (q0.size() != 0) begin
                check("timeout0", q0.size(), 0);
                q0.delete();
            end
            repeat (3) @(negedge clk);
            check("hold_table0", bus0.table_out, t);
            check("hold_match0", bus0.match, (t == ex));
            check("idle_busy0",  bus0.busy, 0);
            if (glitch) check("glitch_bit4", bus0.table_out[4], t[4]);
        end
        glitch0 = 1'b0;
    endtask

    task automatic run1(logic [7:0] ex, int mode, logic [7:0] code);
        logic [7:0] t;
        t = ref_table(mode, code);
        mode1 = mode; code1 = code;
        @(negedge clk);
        bus1.start = 1'b1; bus1.expected = ex;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        q1.push_back('{t, (t == ex), 1'b1, gcyc, 8*(S1+3)+1});
        for (int i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
        if (q1.size() != 0) begin
            check("timeout1", q1.size(), 0);
            q1.delete();
        end
        repeat (2) @(negedge clk);
        check("idle_busy1", bus1.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        logic [7:0] ex;
        gcyc = 0; n_cmp = 0; n_fail = 0;
        mode0 = 0; mode1 = 1; code0 = '0; code1 = '0; glitch0 = 1'b0;
        bus0.start = 1'b0; bus0.expected = '0;
        bus1.start = 1'b0; bus1.expected = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset0("reset");
        check("reset_stable1", bus1.stable, 1);
        rst = 1'b0;

        run0(8'hA6, 0, 8'h00, 1'b0, -1, -1);
        run0(8'h59, 0, 8'h00, 1'b0, -1, -1);
        run0(8'hA6, 0, 8'h00, 1'b1, -1, -1);
        run0(8'hA6, 0, 8'h00, 1'b0, 10, -1);
        run0(8'hA6, 0, 8'h00, 1'b0, -1, 20);
        run0(8'hA6, 0, 8'h00, 1'b0, -1, -1);
        for (int k = 0; k < 6; k++) begin
            code = 8'($urandom);
            ex   = ($urandom_range(0, 1) == 1) ? code : 8'($urandom);
            run0(ex, 2, code, 1'($urandom_range(0, 1)), -1, -1);
        end

        run1(8'hFF, 1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            code = 8'($urandom);
            run1(code, 2, code);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
